// File: rtl/wb_cmd_master_pkg.sv
// wb_cmd_master_pkg
//   Shared constants and types for the command-word to Wishbone master:
//   op codes (CMD_*), response status codes (RSP_*), FSM state encoding
//   (ST_IDLE/ST_BUS) and the packed command/response word layouts.
package wb_cmd_master_pkg;

  localparam logic [1:0] CMD_READ    = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b01;
  localparam logic [1:0] CMD_SETADDR = 2'b10;
  localparam logic [1:0] CMD_RSVD    = 2'b11;

  localparam logic [1:0] RSP_RDATA = 2'b00;
  localparam logic [1:0] RSP_WACK  = 2'b01;
  localparam logic [1:0] RSP_AACK  = 2'b10;
  localparam logic [1:0] RSP_ERR   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] payload;
  } cmd_t;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] data;
  } rsp_t;

  // Every status other than read data carries a zero data field.
  function automatic rsp_t mk_rsp(input logic [1:0] status, input logic [31:0] data);
    rsp_t r;
    r.status = status;
    r.data   = (status == RSP_RDATA) ? data : 32'h0;
    return r;
  endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// wb_cmd_master
//   Turns 34-bit command words from the core into single Wishbone B4 classic
//   cycles and returns one 34-bit response word per accepted command. Holds
//   a word address that post-increments after each ack'd READ/WRITE unless
//   disabled by SETADDR payload bit 30.
//
//   Optional feature macro: WB_TIMEOUT_EN -- when defined, a bus cycle that
//   sees no ack/err for TIMEOUT_CYCLES cycles is abandoned with status 11.
//
// Ports
//   i_clk, i_reset_n          clock, async active-low reset
//   i_cmd_stb, i_cmd_word     command valid / {op[1:0], payload[31:0]}
//   o_cmd_busy                high while a bus cycle is outstanding
//   o_rsp_stb, o_rsp_word     one-cycle response / {status[1:0], data[31:0]}
//   o_wb_*                    Wishbone master outputs (cyc/stb/we/addr/data/sel)
//   i_wb_ack/err/data         Wishbone slave responses
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int AW             = 30,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_cmd_stb,
  input  logic [33:0]   i_cmd_word,
  output logic          o_cmd_busy,
  output logic          o_rsp_stb,
  output logic [33:0]   o_rsp_word,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW+1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data
);

  cmd_t cmd;
  assign cmd = cmd_t'(i_cmd_word);

  state_t        state_q,   state_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic          inc_dis_q, inc_dis_d;
  logic          we_q,      we_d;
  logic [31:0]   wdata_q,   wdata_d;
  logic          rsp_stb_q, rsp_stb_d;
  rsp_t          rsp_q,     rsp_d;

  // Payload bit 31 is reserved in SETADDR and carries no meaning here.
  logic unused_payload;
  assign unused_payload = cmd.payload[31];

`ifdef WB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_hit;
  // The counter holds the number of BUS cycles already completed, so the
  // hit fires in the TIMEOUT_CYCLES-th BUS cycle and cyc drops right after.
  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    inc_dis_d = inc_dis_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rsp_stb_d = 1'b0;
    rsp_d     = rsp_q;
`ifdef WB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_stb) begin
          case (cmd.op)
            CMD_READ: begin
              state_d = ST_BUS;
              we_d    = 1'b0;
`ifdef WB_TIMEOUT_EN
              tmo_cnt_d = '0;
`endif
            end
            CMD_WRITE: begin
              state_d = ST_BUS;
              we_d    = 1'b1;
              wdata_d = cmd.payload;
`ifdef WB_TIMEOUT_EN
              tmo_cnt_d = '0;
`endif
            end
            CMD_SETADDR: begin
              addr_d    = AW'(cmd.payload[29:0]);
              inc_dis_d = cmd.payload[30];
              rsp_stb_d = 1'b1;
              rsp_d     = mk_rsp(RSP_AACK, 32'h0);
            end
            default: begin
              rsp_stb_d = 1'b1;
              rsp_d     = mk_rsp(RSP_ERR, 32'h0);
            end
          endcase
        end
      end
      ST_BUS: begin
        // err has priority over ack when both arrive together.
        if (i_wb_err) begin
          state_d   = ST_IDLE;
          rsp_stb_d = 1'b1;
          rsp_d     = mk_rsp(RSP_ERR, 32'h0);
        end else if (i_wb_ack) begin
          state_d   = ST_IDLE;
          rsp_stb_d = 1'b1;
          rsp_d     = we_q ? mk_rsp(RSP_WACK, 32'h0) : mk_rsp(RSP_RDATA, i_wb_data);
          if (!inc_dis_q) addr_d = addr_q + 1'b1;
        end
`ifdef WB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d   = ST_IDLE;
          rsp_stb_d = 1'b1;
          rsp_d     = mk_rsp(RSP_ERR, 32'h0);
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      inc_dis_q <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rsp_stb_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      inc_dis_q <= inc_dis_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rsp_stb_q <= rsp_stb_d;
      rsp_q     <= rsp_d;
    end
  end

`ifdef WB_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) tmo_cnt_q <= '0;
    else            tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  // Bus strobes come straight from the state flop so the async reset drops
  // them in the same cycle it is applied.
  assign o_cmd_busy = (state_q != ST_IDLE);
  assign o_wb_cyc   = (state_q == ST_BUS);
  assign o_wb_stb   = (state_q == ST_BUS);
  assign o_wb_we    = (state_q == ST_BUS) && we_q;
  assign o_wb_sel   = (state_q == ST_BUS) ? 4'hF : 4'h0;
  assign o_wb_addr  = {addr_q, 2'b00};
  assign o_wb_data  = wdata_q;
  assign o_rsp_stb  = rsp_stb_q;
  assign o_rsp_word = rsp_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
module tb_wb_cmd_master;

  localparam int AW = 30;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_stb = 1'b0;
  logic [33:0]   cmd_word = '0;
  logic          cmd_busy;
  logic          rsp_stb;
  logic [33:0]   rsp_word;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW+1:0] wb_addr;
  logic [31:0]   wb_wdata;
  logic [3:0]    wb_sel;
  logic          wb_ack = 1'b0;
  logic          wb_err = 1'b0;
  logic [31:0]   wb_rdata = '0;

  int checks = 0;
  int failures = 0;

  logic [33:0] exp_q[$];

  // Reference state: the word address and hold flag as the core sees them.
  logic [29:0] m_addr = '0;
  logic        m_hold = 1'b0;

  wb_cmd_master #(.AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cmd_stb(cmd_stb), .i_cmd_word(cmd_word), .o_cmd_busy(cmd_busy),
    .o_rsp_stb(rsp_stb), .o_rsp_word(rsp_word),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdata), .o_wb_sel(wb_sel),
    .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_data(wb_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_stb) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got %h expected none at %0t", rsp_word, $time);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if (rsp_word !== e) begin
          failures++;
          $display("FAIL rsp_word: got %h expected %h at %0t", rsp_word, e, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Plays the core and the slave for one command. err: slave errors;
  // both: ack raised alongside err; poke: core holds a new command during BUS.
  task automatic issue(input logic [1:0] op, input logic [31:0] pl, input int dly,
                       input bit err, input bit both, input bit poke);
    logic [33:0] e;
    logic [29:0] a;
    logic [31:0] rd;
    rd = $urandom;
    a  = m_addr;
    if (op == 2'b00 || op == 2'b01) begin
      if (err) e = {2'b11, 32'h0};
      else begin
        e = (op == 2'b00) ? {2'b00, rd} : {2'b01, 32'h0};
        if (!m_hold) m_addr = m_addr + 30'd1;
      end
    end else if (op == 2'b10) begin
      m_addr = pl[29:0];
      m_hold = pl[30];
      e = {2'b10, 32'h0};
    end else e = {2'b11, 32'h0};
    exp_q.push_back(e);
    cmd_stb = 1'b1; cmd_word = {op, pl};
    step();
    cmd_stb = 1'b0;
    if (op == 2'b00 || op == 2'b01) begin
      chk("cyc_on", {63'h0, wb_cyc}, 64'd1);
      chk("stb_on", {63'h0, wb_stb}, 64'd1);
      chk("busy_on", {63'h0, cmd_busy}, 64'd1);
      chk("we", {63'h0, wb_we}, {63'h0, op == 2'b01});
      chk("addr", {32'h0, wb_addr}, {32'h0, a, 2'b00});
      chk("sel", {60'h0, wb_sel}, 64'hF);
      if (op == 2'b01) chk("wdata", {32'h0, wb_wdata}, {32'h0, pl});
      if (poke) begin cmd_stb = 1'b1; cmd_word = {2'b00, 32'h1234_5678}; end
      for (int i = 0; i < dly; i++) step();
      cmd_stb = 1'b0;
      wb_ack = !err || both; wb_err = err; wb_rdata = rd;
      step();
      wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = $urandom;
      chk("cyc_off", {63'h0, wb_cyc}, 64'd0);
      chk("busy_off", {63'h0, cmd_busy}, 64'd0);
      if (poke) begin
        step();
        chk("no_extra_cycle", {63'h0, wb_cyc}, 64'd0);
      end
    end else begin
      chk("no_bus", {63'h0, wb_cyc}, 64'd0);
      chk("no_busy", {63'h0, cmd_busy}, 64'd0);
    end
  endtask

  initial begin
    int n;
    logic [31:0] rd;
    #2;
    chk("rst_cyc", {63'h0, wb_cyc}, 64'd0);
    chk("rst_rsp", {29'h0, rsp_stb, rsp_word}, 64'd0);
    chk("rst_busy", {63'h0, cmd_busy}, 64'd0);
    chk("rst_addr", {32'h0, wb_addr}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // Directed scenarios.
    issue(2'b10, 32'h4000_0010, 0, 0, 0, 0);
    issue(2'b00, 32'h0, 1, 0, 0, 0);
    issue(2'b00, 32'h0, 0, 0, 0, 0);       // held address: still 0x40
    issue(2'b10, 32'h0000_0005, 0, 0, 0, 0);
    issue(2'b01, 32'hCAFE_F00D, 0, 0, 0, 0);
    issue(2'b00, 32'h0, 2, 0, 0, 0);
    issue(2'b00, 32'h0, 3, 1, 0, 0);        // err: no increment
    issue(2'b00, 32'h0, 0, 1, 1, 0);        // ack+err: err wins
    issue(2'b00, 32'h0, 0, 0, 0, 0);
    issue(2'b10, 32'h3FFF_FFFF, 0, 0, 0, 0);
    issue(2'b01, 32'h5555_AAAA, 2, 0, 0, 1);
    issue(2'b00, 32'h0, 1, 0, 0, 1);        // wrapped to 0
    issue(2'b11, 32'hFFFF_FFFF, 0, 0, 0, 0);

    // Async reset during a bus cycle.
    cmd_stb = 1'b1; cmd_word = {2'b00, 32'h0};
    step();
    cmd_stb = 1'b0;
    chk("pre_rst_cyc", {63'h0, wb_cyc}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", {63'h0, wb_cyc}, 64'd0);
    chk("async_rst_stb", {63'h0, wb_stb}, 64'd0);
    chk("async_rst_rsp", {63'h0, rsp_stb}, 64'd0);
    m_addr = '0; m_hold = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    issue(2'b00, 32'h0, 0, 0, 0, 0);

    // Slave that never answers.
    cmd_stb = 1'b1; cmd_word = {2'b00, 32'h0};
`ifdef WB_TIMEOUT_EN
    exp_q.push_back({2'b11, 32'h0});
    step();
    cmd_stb = 1'b0;
    n = 0;
    while (wb_cyc && n < 200) begin n++; step(); end
    chk("timeout_cycles", 64'(n), 64'(TO));
`else
    rd = $urandom;
    exp_q.push_back({2'b00, rd});
    step();
    cmd_stb = 1'b0;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (wb_cyc) n++;
      step();
    end
    chk("hold_cycles", 64'(n), 64'd1000);
    wb_ack = 1'b1; wb_rdata = rd;
    step();
    wb_ack = 1'b0;
    if (!m_hold) m_addr = m_addr + 30'd1;
`endif
    step();

    // Randomized traffic.
    for (int k = 0; k < 200; k++) begin
      int r;
      logic [1:0] op;
      logic [31:0] pl;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      pl = $urandom;
      if (op == 2'b10 && $urandom_range(0, 1) == 1) pl[29:0] = 30'h3FFF_FFFC | 30'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        wb_ack = 1'b1; wb_err = $urandom_range(0, 1) == 1;   // stray response while idle
        step();
        wb_ack = 1'b0; wb_err = 1'b0;
      end
      issue(op, pl, $urandom_range(0, 3), $urandom_range(0, 6) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    end

    step(); step();
    chk("rsp_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
